// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative MIPS multiply/divide unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: op encoding, FSM states, iteration count, divide-by-zero quotient, magnitude helper.
package mips_cpu_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    localparam int          ITERATIONS = 32;
    localparam logic [31:0] DIV0_LO    = 32'hFFFFFFFF;

    // 33-bit magnitude so that |0x80000000| stays representable.
    function automatic logic [32:0] magnitude(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (33'd0 - {x[31], x}) : {1'b0, x};
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One combinational iteration: shift-add (multiply) or restoring shift-subtract (divide).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every RUN cycle by the parent.
// Ports: is_div selects the step kind; acc_in/acc_out are the 64-bit {hi, lo} accumulator;
//        operand is the 33-bit multiplicand or divisor magnitude.
module mips_cpu_muldiv_step (
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [32:0] operand,
    output logic [63:0] acc_out
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;

    always_comb begin
        // Multiply: add multiplicand to the upper half when the current multiplier
        // bit (acc[0]) is set, then shift the whole accumulator right by one.
        sum     = {1'b0, acc_in[63:32]} + (acc_in[0] ? operand : 33'd0);
        // Divide: shift the next dividend bit into the partial remainder.
        shifted = {acc_in[63:32], acc_in[31]};
        diff    = shifted - operand;
        // Remainder < divisor < 2^32, so shifted < 2^33. If its top bit is set it
        // is certainly >= divisor; otherwise diff[32] is the sign of shifted - divisor.
        ge      = shifted[32] | ~diff[32];
        if (is_div) begin
            acc_out = ge ? {diff[31:0], acc_in[30:0], 1'b1}
                         : {shifted[31:0], acc_in[30:0], 1'b0};
        end else begin
            acc_out = {sum, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register file.
// Latency: start edge T -> done in cycle T+34 (T+1 for multiplies when MIPS_CPU_MULDIV_FAST_MULT_EN is defined).
// Backpressure: start is accepted only when busy=0 (IDLE or DONE); start while busy is ignored.
// Ports: clk, reset (sync, active-low), start/op/a/b request, busy, done pulse (HI/LO write enable),
//        result_lo (product low / quotient), result_hi (product high / remainder).
// Option: MIPS_CPU_MULDIV_FAST_MULT_EN enables a single-cycle multiplier for MULT/MULTU.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    state_e      state, state_nxt;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [63:0] step_out;
    logic [32:0] operand;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;
    logic        div0;

    logic        accept;
    logic        fast_go;
    logic        op_signed;
    logic [32:0] mag_a;
    logic [32:0] mag_b;
    logic [63:0] prod;
    logic [31:0] fix_lo;
    logic [31:0] fix_hi;

    assign accept    = start && (state == ST_IDLE || state == ST_DONE);
    assign op_signed = ~op[0];
    assign mag_a     = magnitude(a, op_signed);
    assign mag_b     = magnitude(b, op_signed);
    assign busy      = (state == ST_RUN) || (state == ST_FIX);
    assign done      = (state == ST_DONE);

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_go   = accept && !op[1];
    assign fast_prod = op_signed ? ($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}))
                                 : ({32'd0, a} * {32'd0, b});
`else
    assign fast_go   = 1'b0;
`endif

    mips_cpu_muldiv_step u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (step_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE,
            ST_DONE: begin
                if (accept) begin
                    state_nxt = fast_go ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt == 5'(ITERATIONS - 1)) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX:  state_nxt = ST_DONE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction applied in FIX. A zero divisor forces the all-ones quotient;
    // the remainder path already yields a (|a| re-signed by a[31]).
    always_comb begin
        prod   = neg_lo ? (64'd0 - acc) : acc;
        fix_lo = prod[31:0];
        fix_hi = prod[63:32];
        if (is_div) begin
            fix_lo = div0   ? DIV0_LO : (neg_lo ? (32'd0 - acc[31:0]) : acc[31:0]);
            fix_hi = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc       <= 64'd0;
            operand   <= 33'd0;
            cnt       <= 5'd0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            div0      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            if (accept) begin
                cnt    <= 5'd0;
                is_div <= op[1];
                if (op[1]) begin
                    // Divide: dividend in the low half, remainder builds in the high half.
                    acc     <= {32'd0, mag_a[31:0]};
                    operand <= mag_b;
                    neg_lo  <= op_signed & (a[31] ^ b[31]);
                    neg_hi  <= op_signed & a[31];
                    div0    <= (b == '0);
                end else begin
                    // Multiply: multiplier in the low half, consumed LSB first.
                    acc     <= {32'd0, mag_b[31:0]};
                    operand <= mag_a;
                    neg_lo  <= op_signed & (a[31] ^ b[31]);
                    neg_hi  <= 1'b0;
                    div0    <= 1'b0;
                end
            end else if (state == ST_RUN) begin
                acc <= step_out;
                cnt <= cnt + 5'd1;
            end

            if (state == ST_FIX) begin
                result_lo <= fix_lo;
                result_hi <= fix_hi;
            end
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
            if (fast_go) begin
                result_lo <= fast_prod[31:0];
                result_hi <= fast_prod[63:32];
            end
`endif
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
module tb_mips_cpu_muldiv;
    import mips_cpu_muldiv_pkg::*;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op_s = 2'b00;
    logic [31:0] a_s = 32'd0;
    logic [31:0] b_s = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    int errors = 0;
    int checks = 0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op_s),
        .a         (a_s),
        .b         (b_s),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] o);
        return (o[1] || !FAST) ? 34 : 1;
    endfunction

    // Present a request so that it is sampled at the next rising edge (edge T);
    // returns #1 into cycle T+1 with start already dropped.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op_s  = o;
        a_s   = x;
        b_s   = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Walk cycles T+1..T+lat. Optionally pulse a foreign start in cycle T+poke_at.
    // Returns #1 into the expected DONE cycle.
    task automatic expect_result(input string tag, input int lat,
                                 input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                                 input int poke_at);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (k == poke_at + 1) start = 1'b0;
            if (k == poke_at) begin
                start = 1'b1;
                op_s  = OP_MULT;
                a_s   = 32'd9;
                b_s   = 32'd9;
            end
            if (k < lat) begin
                if (done !== 1'b0 || busy !== 1'b1) begin
                    check({tag, ":early"}, {30'd0, busy, done}, 32'h2);
                    return;
                end
            end
        end
        check({tag, ":done"}, {31'd0, done}, 32'd1);
        check({tag, ":busy"}, {31'd0, busy}, 32'd0);
        check({tag, ":lo"}, result_lo, exp_lo);
        check({tag, ":hi"}, result_hi, exp_hi);
    endtask

    task automatic one_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        launch(o, x, y);
        expect_result(tag, lat_of(o), exp_lo, exp_hi, 0);
        @(posedge clk);
        #1;
        check({tag, ":single_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int pulses;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst:busy", {31'd0, busy}, 32'd0);
        check("rst:done", {31'd0, done}, 32'd0);
        check("rst:lo", result_lo, 32'd0);
        check("rst:hi", result_hi, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Multiply patterns.
        one_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
        one_op("mult_m1m1", OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        one_op("mult_m3x4", OP_MULT,  32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFF4, 32'hFFFFFFFF);
        one_op("mult_min2", OP_MULT,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);
        one_op("mult_minx1", OP_MULT, 32'h80000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF);

        // Divide patterns.
        one_op("div_m7d2",  OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF);
        one_op("div_ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
        one_op("divu_by0",  OP_DIVU, 32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234);
        one_op("div_m5by0", OP_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB);

        // Ignored start while busy, then back-to-back start in the DONE cycle.
        launch(OP_DIVU, 32'd100, 32'd7);
        expect_result("divu_poke", 34, 32'd14, 32'd2, 5);
        launch(OP_DIVU, 32'd1000, 32'd10);
        expect_result("divu_b2b", 34, 32'd100, 32'd0, 0);

        // Reset held low for 3 cycles in the middle of a DIV.
        launch(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort:busy", {31'd0, busy}, 32'd0);
            check("abort:done", {31'd0, done}, 32'd0);
        end
        check("abort:lo", result_lo, 32'd0);
        check("abort:hi", result_hi, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("abort:no_pulse", 32'(pulses), 32'd0);

        one_op("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd15, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv.md
# mips_cpu_muldiv

Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI/LO register file. It accepts rs/rt operands from the decode/execute stage and produces a 64-bit result as lo/hi words. A one-cycle `done` pulse drives the HI/LO write enable.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: request to begin an operation. Accepted only when `busy`=0.
- `op`  in  2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `a`  in  32: rs operand (multiplicand or dividend). Sampled with `start`.
- `b`  in  32: rt operand (multiplier or divisor). Sampled with `start`.
- `busy`  out  1: high while an operation is in progress.
- `done`  out  1: single-cycle pulse when `result_lo`/`result_hi` become valid. Connects to the HI/LO `write_enable`.
- `result_lo`  out  32: LO result (product low word, or quotient).
- `result_hi`  out  32: HI result (product high word, or remainder).

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: 32 iterations.
  - FIX: sign correction.
  - DONE: `done`=1.
- Transitions:
  - IDLE -> RUN on `start`.
  - RUN -> FIX after the 32nd iteration.
  - FIX -> DONE.
  - DONE -> RUN if `start` is high in the DONE cycle, else DONE -> IDLE.
- Signed ops (MULT, DIV): absolute values of `a` and `b` are latched at start, along with the result signs.
  - Product sign = a[31]^b[31].
  - Quotient sign = a[31]^b[31].
  - Remainder sign = a[31].
- Multiply: 32-step shift-add on magnitudes into a 64-bit accumulator. FIX negates the accumulator if the sign flag is set.
- Divide: 32-step restoring shift-subtract.
  - The quotient is truncated toward zero.
  - FIX negates the quotient and/or remainder per their sign flags.
- Arithmetic rules:
  - Magnitudes are 33-bit internally, so |0x80000000| is representable.
  - The subtract is 33-bit.
  - The accumulator is 64-bit.
- Division by zero: `result_lo`=32'hFFFFFFFF and `result_hi`=`a` for both DIV and DIVU. Normal latency applies; no exception.
- DIV 0x80000000 / 0xFFFFFFFF: `result_lo`=0x80000000, `result_hi`=0.
- `start` while `busy`=1 is ignored. The operation in flight is unaffected.
- `result_lo`/`result_hi` are updated only on entry to DONE and hold their value until the next DONE.
- Reset mid-operation:
  - Go to IDLE with `busy`=0 and `done`=0.
  - No pulse is emitted for the aborted operation.
  - Results are cleared to 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, state IDLE.
- `start` is sampled at edge T:
  - `busy`=1 during cycles T+1..T+33 (RUN T+1..T+32, FIX T+33).
  - `done`=1 and results valid during cycle T+34.
  - `busy`=0 in the DONE cycle.
- Latency is 34 cycles from start edge to done cycle for every op (divide, and multiply without the fast option).
- Back-to-back: a `start` in the DONE cycle is accepted. The next `done` occurs 34 cycles later, with no IDLE bubble.
- `done` is never high for more than one consecutive cycle unless back-to-back fast multiplies are issued.

## Configuration
- `MIPS_CPU_MULDIV_FAST_MULT_EN`, when defined:
  - MULT/MULTU use a single-cycle 64-bit signed/unsigned multiplier registered on entry to DONE.
  - Path is IDLE -> DONE, so `done` is high in cycle T+1 and `busy` never rises.
  - Divide is unchanged.
- When undefined: all ops use the iterative path with 34-cycle latency, and no `*` operator is synthesised.

## Structure
- Package `mips_cpu_muldiv_pkg`:
  - op enum: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state enum.
  - ITERATIONS = 32.
  - DIV0_LO = 32'hFFFFFFFF.
- One sub-module, `mips_cpu_muldiv_step`: a combinational single-iteration datapath doing either a shift-add step (multiply) or a shift-subtract step (divide), selected by op.
- Sign conditioning (abs/negate) and the FSM stay in the top module.

## Test plan
- Reset held low for 3 cycles mid-DIV, then released: `busy`=0, `done` never pulses, results = 0. A new MULTU 3×5 then gives lo=15, hi=0 at T+34.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> lo=0x00000001, hi=0xFFFFFFFE. MULT of the same operands -> lo=1, hi=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 1234 / 0 -> lo=0xFFFFFFFF, hi=1234 at T+34.
- `start` pulsed at T+5 during a busy op with different operands: ignored, and the first result is correct. Then `start` in the DONE cycle: accepted, with the second `done` exactly 34 cycles later.
- With `MIPS_CPU_MULDIV_FAST_MULT_EN`: MULT -3 × 4 -> `done` at T+1, lo=0xFFFFFFF4, hi=0xFFFFFFFF, `busy` stays 0. DIV latency is still 34 cycles.
